conv_acc_ctrl: RTL and testbench
================================

Name: conv_acc_ctrl

Overview:
- Sequences the 9-input, 4-stage pipelined adder tree across the input channels of one 3x3 convolution output pixel.
- Issues one tree operation per channel when operands are available and counts results returning from the tree pipeline.
- Accumulates the 20-bit channel partial sums into a wide signed accumulator and presents the final sum to the downstream stage with a valid/ready handshake.
- Sits between the operand/multiplier front end and the requantization stage.

Parameters:
- CIN_W, 8, width of the channel-count field (jobs of 1..2^CIN_W-1 channels).
- ACC_W, 28, accumulator and result width. Must satisfy ACC_W >= 20+CIN_W.
- TREE_LAT, 4, adder tree latency in cycles (tree valid in to tree valid out). Used for flush.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- start_i  in  1  job start pulse. Sampled only in IDLE.
- cin_i  in  CIN_W  number of input channels for the job. Sampled with start_i.
- clear_i  in  1  synchronous soft abort.
- src_rdy_i  in  1  operands for the next channel are present at the multiplier outputs this cycle.
- tree_vld_o  out  1  drives the tree vld_i. Also acts as the operand pop strobe.
- tree_vld_i  in  1  tree output valid.
- tree_acc_i  in  20  tree output sum, signed.
- psum_o  out  ACC_W  final signed channel sum.
- psum_vld_o  out  1  psum_o valid.
- psum_rdy_i  in  1  downstream accepts psum_o.
- busy_o  out  1  high in every state except IDLE.

Behaviour:
- Reset values: psum_o=0, psum_vld_o=0, busy_o=0, tree_vld_o=0. Internal reset: state=IDLE, acc=0, all counters=0.
- States: IDLE, ISSUE, DRAIN, OUT, FLUSH.
- IDLE:
  - start_i=1 and cin_i!=0: latch cin_i into cin_q, clear acc, issue_cnt and ret_cnt; go to ISSUE.
  - start_i=1 and cin_i=0: ignored; stay in IDLE, no output.
- ISSUE:
  - tree_vld_o = (state==ISSUE) & src_rdy_i, combinational, so it aligns with the operands in the same cycle.
  - Each issue increments issue_cnt.
  - An issue with issue_cnt==cin_q-1 moves the FSM to DRAIN.
  - src_rdy_i=0 inserts bubbles; there is no timeout.
- Accumulation (ISSUE and DRAIN):
  - On tree_vld_i: acc <= acc + sign-extended tree_acc_i; ret_cnt++.
  - Arithmetic is two's complement, modulo 2^ACC_W; no saturation.
  - The return with ret_cnt==cin_q-1: psum_o <= acc + sext(tree_acc_i), psum_vld_o <= 1, next state OUT. This can fire from ISSUE only if the tree latency were 0; in practice it fires from DRAIN.
  - tree_vld_i in IDLE, OUT or FLUSH is ignored.
- OUT:
  - psum_o and psum_vld_o hold stable until psum_rdy_i=1.
  - On the handshake cycle: psum_vld_o <= 0, go to IDLE.
  - start_i is ignored in OUT; the next job may start the cycle after the handshake.
- Latency:
  - Accept start at cycle T. First issue is possible at T+1.
  - With src_rdy_i held high, psum_vld_o rises at T+cin+TREE_LAT+1 (cin=1: T+6).
- clear_i:
  - From any non-IDLE state: tree_vld_o forced 0 that cycle, psum_vld_o <= 0, acc cleared, go to FLUSH.
  - FLUSH waits TREE_LAT cycles, discarding tree results in flight, then goes to IDLE.
  - clear_i in IDLE has no effect.
  - clear_i has priority over start_i, tree_vld_i and psum_rdy_i in the same cycle.
- Async reset mid-job: immediate return to reset values. In-flight tree results arriving after reset release are ignored, because the FSM is in IDLE.

Test Plan:
- Bench instantiates the 4-stage adder tree, or a 4-cycle delay model, between tree_vld_o and tree_vld_i.
- Basic: cin=1, tree sum 1234, src_rdy_i=1 -> psum_o=1234, psum_vld_o rises 6 cycles after start.
- Multi-channel with gaps: cin=3, tree sums 100, -50, 7, src_rdy_i low for 2 cycles between channels -> exactly 3 tree_vld_o pulses, psum_o=57.
- Backpressure: psum_rdy_i low for 5 cycles, start_i pulsed during OUT -> psum_o stable at 57, start ignored, busy_o=1; IDLE one cycle after rdy.
- Extremes: cin=255, every sum -524288 -> psum_o=-133693440 with no wrap. cin=0 start -> busy_o stays 0, no tree_vld_o.
- Abort: clear_i after 2 of 4 issues -> FLUSH for 4 cycles, no psum_vld_o. Next job cin=2 with sums 10, 20 -> psum_o=30, unaffected by the discarded results.
- Reset: rstn low mid-DRAIN -> all outputs 0 at once. After release, a new cin=1 job returns the correct sum.

Source files
------------

// File: rtl/conv_acc_ctrl_if.sv
// Handshake/data bundle between the conv accumulator controller, its operand front end,
// the 9-input adder tree and the downstream requantization stage.
interface conv_acc_ctrl_if #(
  parameter int CIN_W = 8,
  parameter int ACC_W = 28
);
  logic                    start_i;
  logic [CIN_W-1:0]        cin_i;
  logic                    clear_i;
  logic                    src_rdy_i;
  logic                    tree_vld_o;
  logic                    tree_vld_i;
  logic signed [19:0]      tree_acc_i;
  logic signed [ACC_W-1:0] psum_o;
  logic                    psum_vld_o;
  logic                    psum_rdy_i;
  logic                    busy_o;

  // Controller side.
  modport slave (
    input  start_i, cin_i, clear_i, src_rdy_i, tree_vld_i, tree_acc_i, psum_rdy_i,
    output tree_vld_o, psum_o, psum_vld_o, busy_o
  );

  // Environment side: front end, tree and downstream consumer.
  modport master (
    output start_i, cin_i, clear_i, src_rdy_i, tree_vld_i, tree_acc_i, psum_rdy_i,
    input  tree_vld_o, psum_o, psum_vld_o, busy_o
  );
endinterface

// File: rtl/conv_acc_ctrl.sv
// Issues one adder-tree op per input channel, accumulates the returning 20-bit sums,
// and holds the final wide signed sum on a valid/ready output until it is accepted.
module conv_acc_ctrl #(
  parameter int CIN_W    = 8,
  parameter int ACC_W    = 28,
  parameter int TREE_LAT = 4
) (
  input  logic            clk,
  input  logic            rstn,
  conv_acc_ctrl_if.slave  bus
);

  localparam int FL_W = (TREE_LAT > 1) ? $clog2(TREE_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_OUT,
    S_FLUSH
  } state_t;

  state_t           state_q;
  logic [CIN_W-1:0] cin_q;
  logic [CIN_W-1:0] issue_cnt_q;
  logic [CIN_W-1:0] ret_cnt_q;
  logic [FL_W-1:0]  flush_cnt_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] psum_q;
  logic             psum_vld_q;

  logic [ACC_W-1:0] tree_sext;
  logic [ACC_W-1:0] acc_d;
  logic             abort;
  logic             issue;
  logic             ret;
  logic             last_issue;
  logic             last_ret;

  assign tree_sext  = {{(ACC_W-20){bus.tree_acc_i[19]}}, bus.tree_acc_i};
  assign acc_d      = acc_q + tree_sext;
  assign abort      = bus.clear_i && (state_q != S_IDLE);

  // Issue is combinational so the pop strobe lines up with the operands on the same cycle.
  assign issue      = (state_q == S_ISSUE) && bus.src_rdy_i && !bus.clear_i;
  assign ret        = ((state_q == S_ISSUE) || (state_q == S_DRAIN)) && bus.tree_vld_i;
  assign last_issue = (issue_cnt_q == (cin_q - CIN_W'(1)));
  assign last_ret   = (ret_cnt_q == (cin_q - CIN_W'(1)));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      cin_q       <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      flush_cnt_q <= '0;
      acc_q       <= '0;
      psum_q      <= '0;
      psum_vld_q  <= 1'b0;
    end else if (abort) begin
      state_q     <= S_FLUSH;
      flush_cnt_q <= '0;
      acc_q       <= '0;
      psum_vld_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start_i && (bus.cin_i != '0)) begin
            cin_q       <= bus.cin_i;
            acc_q       <= '0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE, S_DRAIN: begin
          if (issue) begin
            issue_cnt_q <= issue_cnt_q + CIN_W'(1);
            if (last_issue) state_q <= S_DRAIN;
          end
          // The final return outranks the ISSUE->DRAIN move; only reachable early with a zero-latency tree.
          if (ret) begin
            acc_q     <= acc_d;
            ret_cnt_q <= ret_cnt_q + CIN_W'(1);
            if (last_ret) begin
              psum_q     <= acc_d;
              psum_vld_q <= 1'b1;
              state_q    <= S_OUT;
            end
          end
        end
        S_OUT: begin
          if (bus.psum_rdy_i) begin
            psum_vld_q <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        S_FLUSH: begin
          // Let every result already inside the tree fall out before taking a new job.
          if (flush_cnt_q == FL_W'(TREE_LAT - 1)) begin
            state_q <= S_IDLE;
          end else begin
            flush_cnt_q <= flush_cnt_q + FL_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.tree_vld_o = issue;
  assign bus.psum_o     = psum_q;
  assign bus.psum_vld_o = psum_vld_q;
  assign bus.busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_conv_acc_ctrl.sv
// Bench for conv_acc_ctrl: 4-cycle tree delay model, vector table, directed corner cases and random jobs.
module tb_conv_acc_ctrl;
  localparam int CIN_W = 8, ACC_W = 28, TREE_LAT = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int n_chk = 0, n_fail = 0;

  conv_acc_ctrl_if #(.CIN_W(CIN_W), .ACC_W(ACC_W)) bus ();
  conv_acc_ctrl #(.CIN_W(CIN_W), .ACC_W(ACC_W), .TREE_LAT(TREE_LAT)) dut (
    .clk(clk), .rstn(rstn), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Tree stand-in: each issue pops the next channel sum and returns it TREE_LAT cycles later.
  logic signed [19:0] sums_q[$];
  logic [TREE_LAT-1:0] vp = '0;
  logic [19:0] dp [TREE_LAT];
  int issue_total = 0;

  always @(posedge clk) begin
    vp <= {vp[TREE_LAT-2:0], bus.tree_vld_o};
    for (int i = TREE_LAT - 1; i > 0; i--) dp[i] <= dp[i-1];
    if (bus.tree_vld_o) begin
      issue_total <= issue_total + 1;
      dp[0] <= (sums_q.size() > 0) ? sums_q.pop_front() : 20'sd0;
    end
  end
  assign bus.tree_vld_i = vp[TREE_LAT-1];
  assign bus.tree_acc_i = dp[TREE_LAT-1];

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint psum_now();
    return longint'(bus.psum_o);
  endfunction

  // Reference: plain signed sum of the channel values, wrapped to ACC_W bits.
  function automatic longint wrap_acc(input longint s);
    longint t;
    t = s & ((longint'(1) << ACC_W) - 1);
    if (t >= (longint'(1) << (ACC_W - 1))) t -= (longint'(1) << ACC_W);
    return t;
  endfunction

  task automatic run_job(input string tag, input int cin, input int gap, input int rdy_dly,
                         input longint exp, input int exp_lat, input bit poke_start);
    int lat, k, base, budget;
    bit got;
    base = issue_total;
    @(posedge clk); #1 bus.start_i = 1'b1; bus.cin_i = CIN_W'(cin);
    @(posedge clk); #1 bus.start_i = 1'b0;
    lat = 1; k = 0; got = 1'b0;
    budget = (cin * (gap + 1) + TREE_LAT + 10) * 2;
    while (!got && lat < budget) begin
      bus.src_rdy_i = ((k % (gap + 1)) == 0);
      k++;
      @(negedge clk);
      if (bus.psum_vld_o) got = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    bus.src_rdy_i = 1'b0;
    check($sformatf("%s_vld_seen", tag), longint'(got), 1);
    if (!got) return;
    if (exp_lat > 0) check($sformatf("%s_latency", tag), lat, exp_lat);
    check($sformatf("%s_psum", tag), psum_now(), exp);
    check($sformatf("%s_issues", tag), issue_total - base, cin);
    for (int d = 0; d < rdy_dly; d++) begin
      @(posedge clk); #1;
      bus.start_i = poke_start && (d == 1);
      bus.cin_i   = CIN_W'(1);
      @(negedge clk);
      check($sformatf("%s_hold_psum", tag), psum_now(), exp);
      check($sformatf("%s_hold_busy", tag), {bus.psum_vld_o, bus.busy_o}, 3);
    end
    @(posedge clk); #1 bus.start_i = 1'b0; bus.psum_rdy_i = 1'b1;
    @(posedge clk); #1 bus.psum_rdy_i = 1'b0;
    @(negedge clk);
    check($sformatf("%s_after_hs", tag), {bus.psum_vld_o, bus.busy_o}, 0);
    @(negedge clk);
    check($sformatf("%s_idle_hold", tag), bus.busy_o, 0);
  endtask

  typedef struct {
    int     cin;
    int     val;
    int     step;
    int     gap;
    int     dly;
    longint exp;
    int     lat;
  } vec_t;

  initial begin
    vec_t tbl[5];
    int base;
    tbl[0] = '{1, 1234, 0, 0, 0, 1234, 6};
    tbl[1] = '{4, 10, 10, 1, 1, 100, 0};
    tbl[2] = '{255, -524288, 0, 0, 0, -133693440, 260};
    tbl[3] = '{5, -3, -1, 0, 2, -25, 10};
    tbl[4] = '{2, 524287, 0, 1, 0, 1048574, 0};

    bus.start_i = 1'b0; bus.cin_i = '0; bus.clear_i = 1'b0;
    bus.src_rdy_i = 1'b0; bus.psum_rdy_i = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {bus.psum_vld_o, bus.busy_o, bus.tree_vld_o}, 0);
    check("rst_psum", psum_now(), 0);
    @(posedge clk); #1 rstn = 1'b1;

    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < tbl[t].cin; i++) sums_q.push_back(20'(tbl[t].val + i * tbl[t].step));
      run_job($sformatf("vec%0d", t), tbl[t].cin, tbl[t].gap, tbl[t].dly, tbl[t].exp, tbl[t].lat, 1'b0);
    end

    // Channels with gaps, then a long backpressure with a stray start inside OUT.
    sums_q.push_back(20'sd100); sums_q.push_back(-20'sd50); sums_q.push_back(20'sd7);
    run_job("gap_bp", 3, 2, 5, 57, 0, 1'b1);

    // Zero-channel start is dropped.
    base = issue_total;
    @(posedge clk); #1 bus.start_i = 1'b1; bus.cin_i = '0;
    @(posedge clk); #1 bus.start_i = 1'b0; bus.src_rdy_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("cin0_busy", bus.busy_o, 0);
      @(posedge clk); #1;
    end
    bus.src_rdy_i = 1'b0;
    check("cin0_issues", issue_total - base, 0);

    // Abort after two of four issues.
    sums_q.push_back(20'sd1); sums_q.push_back(20'sd2);
    sums_q.push_back(20'sd3); sums_q.push_back(20'sd4);
    base = issue_total;
    @(posedge clk); #1 bus.start_i = 1'b1; bus.cin_i = CIN_W'(4);
    @(posedge clk); #1 bus.start_i = 1'b0; bus.src_rdy_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 bus.clear_i = 1'b1;
    @(negedge clk);
    check("abort_issue_blocked", bus.tree_vld_o, 0);
    @(posedge clk); #1 bus.clear_i = 1'b0; bus.src_rdy_i = 1'b0;
    for (int i = 0; i < TREE_LAT; i++) begin
      @(negedge clk);
      check("abort_flush_busy", {bus.psum_vld_o, bus.busy_o}, 1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("abort_flush_done", {bus.psum_vld_o, bus.busy_o}, 0);
    check("abort_issues", issue_total - base, 2);
    sums_q.delete();
    sums_q.push_back(20'sd10); sums_q.push_back(20'sd20);
    run_job("abort_next", 2, 0, 0, 30, 0, 1'b0);

    // Brief async reset in DRAIN; results still inside the tree arrive after release.
    sums_q.push_back(20'sd5); sums_q.push_back(20'sd6); sums_q.push_back(20'sd7);
    base = issue_total;
    @(posedge clk); #1 bus.start_i = 1'b1; bus.cin_i = CIN_W'(3);
    @(posedge clk); #1 bus.start_i = 1'b0; bus.src_rdy_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check("reset_mid_outputs", {bus.psum_vld_o, bus.busy_o, bus.tree_vld_o}, 0);
    check("reset_mid_psum", psum_now(), 0);
    #1 rstn = 1'b1;
    check("reset_mid_issues", issue_total - base, 3);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("reset_after_idle", {bus.psum_vld_o, bus.busy_o, bus.tree_vld_o}, 0);
    end
    bus.src_rdy_i = 1'b0;
    sums_q.delete();
    sums_q.push_back(20'sd99);
    run_job("reset_next", 1, 0, 0, 99, 6, 1'b0);

    // Random jobs against the plain-sum reference.
    for (int j = 0; j < 8; j++) begin
      int cin, gap, dly;
      longint s;
      logic signed [19:0] v;
      cin = $urandom_range(1, 24);
      gap = $urandom_range(0, 2);
      dly = $urandom_range(0, 3);
      s = 0;
      for (int i = 0; i < cin; i++) begin
        v = 20'($urandom_range(0, 20'hFFFFF));
        sums_q.push_back(v);
        s += longint'(v);
      end
      run_job($sformatf("rand%0d", j), cin, gap, dly, wrap_acc(s), 0, 1'b0);
      sums_q.delete();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
